// File: rtl/apb2per_ext.sv
`default_nettype none
// ============================================================================
//  Module      : apb2per_ext
//  Description : APB slave to peripheral-master bridge. Forwards an APB access
//                as a req/gnt request, optionally waits for the r_valid
//                response, and can time out a stalled access with PSLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb2per_ext #(
  parameter int unsigned PER_ADDR_WIDTH  = 32,
  parameter int unsigned APB_ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WRITE_WAIT_RESP = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
  output logic                      per_master_we_o,
  output logic [DATA_WIDTH-1:0]     per_master_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   per_master_be_o,
  input  logic                      per_master_gnt_i,
  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [DATA_WIDTH-1:0]     per_master_r_rdata_i
);

  // A zero timeout still needs a legal one-bit counter vector.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RESP = 2'd1,
    ST_DRAIN     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access;
  logic             timeout_hit;
  logic             write_on_gnt;

  assign access       = PSEL & PENABLE;
  assign write_on_gnt = PWRITE & (WRITE_WAIT_RESP == 0);

  // Timeout comparison exists only when a timeout is configured.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Address is zero-extended or truncated to the peripheral width.
  generate
    if (PER_ADDR_WIDTH > APB_ADDR_WIDTH) begin : g_addr_ext
      assign per_master_add_o = {{(PER_ADDR_WIDTH - APB_ADDR_WIDTH){1'b0}}, PADDR};
    end else begin : g_addr_trunc
      assign per_master_add_o = PADDR[PER_ADDR_WIDTH-1:0];
    end
  endgenerate

  assign per_master_wdata_o = PWDATA;
  assign per_master_be_o    = PWRITE ? PSTRB : {(DATA_WIDTH/8){1'b1}};

  // Next-state, timeout counter and combinational handshake outputs.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    per_master_req_o = 1'b0;
    per_master_we_o  = 1'b0;
    PREADY           = 1'b0;
    PSLVERR          = 1'b0;
    PRDATA           = '0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          per_master_we_o = PWRITE;
          if (per_master_gnt_i) begin
            // Grant wins over a coincident timeout.
            per_master_req_o = 1'b1;
            if (write_on_gnt) begin
              PREADY = 1'b1;
              cnt_d  = '0;
            end else begin
              state_d = ST_WAIT_RESP;
            end
          end else if (timeout_hit) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
            cnt_d   = '0;
          end else begin
            per_master_req_o = 1'b1;
            cnt_d            = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_RESP: begin
        if (per_master_r_valid_i) begin
          PREADY  = 1'b1;
          PSLVERR = per_master_r_opc_i;
          PRDATA  = per_master_r_rdata_i;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          // The late response must still be absorbed before a new request.
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (per_master_r_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb2per_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb2per_ext
//  Description : Directed self-checking bench for apb2per_ext. Three instances
//                cover zero-wait writes, write-response/timeout mode and a
//                64-bit data path with a narrower peripheral address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb2per_ext;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Stimulus shared by all instances; each has its own PSEL.
  logic [31:0] paddr, pwdata, rdata;
  logic        pwrite, penable, gnt, rvalid, opc;
  logic [3:0]  pstrb;
  logic        psel_a, psel_b, psel_c;
  logic [63:0] pwdata_c, rdata_c;
  logic [7:0]  pstrb_c;

  logic [31:0] prdata_a, add_a, wdata_a, prdata_b, add_b, wdata_b;
  logic        pready_a, pslverr_a, req_a, we_a, pready_b, pslverr_b, req_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [63:0] prdata_c, wdata_c;
  logic [15:0] add_c;
  logic        pready_c, pslverr_c, req_c, we_c;
  logic [7:0]  be_c;

  apb2per_ext u_a (
    .clk_i(clk), .rst_ni(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel_a), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata_a),
    .PREADY(pready_a), .PSLVERR(pslverr_a), .per_master_req_o(req_a),
    .per_master_add_o(add_a), .per_master_we_o(we_a), .per_master_wdata_o(wdata_a),
    .per_master_be_o(be_a), .per_master_gnt_i(gnt), .per_master_r_valid_i(rvalid),
    .per_master_r_opc_i(opc), .per_master_r_rdata_i(rdata)
  );

  apb2per_ext #(.WRITE_WAIT_RESP(1), .TIMEOUT_CYCLES(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel_b), .PENABLE(penable), .PSTRB(pstrb), .PRDATA(prdata_b),
    .PREADY(pready_b), .PSLVERR(pslverr_b), .per_master_req_o(req_b),
    .per_master_add_o(add_b), .per_master_we_o(we_b), .per_master_wdata_o(wdata_b),
    .per_master_be_o(be_b), .per_master_gnt_i(gnt), .per_master_r_valid_i(rvalid),
    .per_master_r_opc_i(opc), .per_master_r_rdata_i(rdata)
  );

  apb2per_ext #(.DATA_WIDTH(64), .PER_ADDR_WIDTH(16)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .PADDR(paddr), .PWDATA(pwdata_c), .PWRITE(pwrite),
    .PSEL(psel_c), .PENABLE(penable), .PSTRB(pstrb_c), .PRDATA(prdata_c),
    .PREADY(pready_c), .PSLVERR(pslverr_c), .per_master_req_o(req_c),
    .per_master_add_o(add_c), .per_master_we_o(we_c), .per_master_wdata_o(wdata_c),
    .per_master_be_o(be_c), .per_master_gnt_i(gnt), .per_master_r_valid_i(rvalid),
    .per_master_r_opc_i(opc), .per_master_r_rdata_i(rdata_c)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    psel_a = 1'b0; psel_b = 1'b0; psel_c = 1'b0; penable = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; opc = 1'b0;
  endtask

  initial begin
    idle();
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; rdata = '0;
    pwdata_c = '0; pstrb_c = '0; rdata_c = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready_a", pready_a, 0);  chk("rst_pslverr_a", pslverr_a, 0);
    chk("rst_prdata_a", prdata_a, 0);  chk("rst_req_a", req_a, 0);
    chk("rst_we_a", we_a, 0);          chk("rst_pready_b", pready_b, 0);
    chk("rst_req_c", req_c, 0);
    rst_n = 1'b1;

    // Zero-wait write
    nxt(); psel_a = 1; pwrite = 1; paddr = 32'h1A10_0004; pwdata = 32'hDEADBEEF; pstrb = 4'h3;
    #2 chk("wr_setup_req", req_a, 0);
    nxt(); penable = 1; gnt = 1;
    #2 chk("wr_req", req_a, 1);           chk("wr_we", we_a, 1);
       chk("wr_add", add_a, 32'h1A10_0004); chk("wr_wdata", wdata_a, 32'hDEADBEEF);
       chk("wr_be", be_a, 4'h3);           chk("wr_pready", pready_a, 1);
       chk("wr_pslverr", pslverr_a, 0);
    nxt(); idle();
    #2 chk("wr_after_pready", pready_a, 0);

    // Read: gnt on third access cycle, r_valid on third wait cycle
    nxt(); psel_a = 1; penable = 1; pwrite = 0; paddr = 32'h100;
    #2 chk("rd_req_c1", req_a, 1); chk("rd_pready_c1", pready_a, 0); chk("rd_be", be_a, 4'hF);
       chk("rd_we", we_a, 0);
    nxt();
    #2 chk("rd_req_c2", req_a, 1);
    nxt(); gnt = 1;
    #2 chk("rd_req_gnt", req_a, 1); chk("rd_pready_gnt", pready_a, 0);
    nxt(); gnt = 0;
    #2 chk("rd_wait1_req", req_a, 0); chk("rd_wait1_pready", pready_a, 0);
    nxt();
    #2 chk("rd_wait2_pready", pready_a, 0); chk("rd_wait2_prdata", prdata_a, 0);
    nxt(); rvalid = 1; rdata = 32'h1234_5678;
    #2 chk("rd_pready", pready_a, 1); chk("rd_prdata", prdata_a, 32'h1234_5678);
       chk("rd_pslverr", pslverr_a, 0);
    nxt(); idle();
    #2 chk("rd_prdata_idle", prdata_a, 0);

    // Access withdrawn before grant
    nxt(); psel_a = 1; penable = 1;
    #2 chk("drop_req_before", req_a, 1);
    nxt(); penable = 0;
    #2 chk("drop_req", req_a, 0); chk("drop_pready", pready_a, 0);
    nxt(); idle();

    // Write waiting for an error response
    nxt(); psel_b = 1; pwrite = 1; paddr = 32'h20; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    nxt(); penable = 1; gnt = 1;
    #2 chk("wwr_req", req_b, 1); chk("wwr_we", we_b, 1); chk("wwr_pready_gnt", pready_b, 0);
    nxt(); gnt = 0;
    #2 chk("wwr_wait_pready", pready_b, 0);
    nxt(); rvalid = 1; opc = 1;
    #2 chk("wwr_pready", pready_b, 1); chk("wwr_pslverr", pslverr_b, 1);
    nxt(); idle();

    // Grant never arrives: timeout on the fifth access cycle
    nxt(); psel_b = 1; pwrite = 0; paddr = 32'h40;
    nxt(); penable = 1;
    for (int k = 1; k <= 5; k++) begin
      #2;
      if (k < 5) begin
        chk("to_gnt_req", req_b, 1); chk("to_gnt_pready", pready_b, 0);
      end else begin
        chk("to_gnt_pready", pready_b, 1); chk("to_gnt_pslverr", pslverr_b, 1);
        chk("to_gnt_req_forced", req_b, 0);
      end
      nxt();
    end
    idle();
    #2 chk("to_gnt_after", pready_b, 0);
    nxt(); psel_b = 1; penable = 1;
    #2 chk("to_gnt_idle_req", req_b, 1); chk("to_gnt_cnt_clr", pready_b, 0);
    nxt(); idle();

    // Granted read with missing response, then a held back-to-back read
    nxt(); psel_b = 1; penable = 1; pwrite = 0; paddr = 32'h80; gnt = 1;
    #2 chk("to_rsp_req", req_b, 1); chk("to_rsp_pready_gnt", pready_b, 0);
    nxt(); gnt = 0;
    for (int k = 1; k <= 5; k++) begin
      #2;
      if (k < 5) begin
        chk("to_rsp_wait_pready", pready_b, 0);
      end else begin
        chk("to_rsp_pready", pready_b, 1); chk("to_rsp_pslverr", pslverr_b, 1);
      end
      nxt();
    end
    penable = 0;
    #2 chk("drain_setup_req", req_b, 0);
    nxt(); penable = 1; gnt = 1;
    #2 chk("drain_req1", req_b, 0); chk("drain_pready1", pready_b, 0);
    nxt();
    #2 chk("drain_req2", req_b, 0);
    nxt(); rvalid = 1; rdata = 32'hBAD0_BAD0;
    #2 chk("drain_late_req", req_b, 0); chk("drain_late_pready", pready_b, 0);
       chk("drain_late_prdata", prdata_b, 0);
    nxt(); rvalid = 0;
    #2 chk("b2b_req", req_b, 1); chk("b2b_pready_gnt", pready_b, 0);
    nxt(); gnt = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
    #2 chk("b2b_pready", pready_b, 1); chk("b2b_pslverr", pslverr_b, 0);
       chk("b2b_prdata", prdata_b, 32'hCAFE_F00D);
    nxt(); idle();

    // Reset in the middle of a read
    nxt(); psel_b = 1; penable = 1; pwrite = 0; gnt = 1;
    nxt(); idle(); rst_n = 0;
    #2 chk("mid_rst_req", req_b, 0); chk("mid_rst_pready", pready_b, 0);
       chk("mid_rst_we", we_b, 0);
    nxt(); rst_n = 1; rvalid = 1; opc = 1; rdata = 32'h0000_0012;
    #2 chk("post_rst_pready", pready_b, 0); chk("post_rst_pslverr", pslverr_b, 0);
       chk("post_rst_prdata", prdata_b, 0);
    nxt(); idle();

    // 64-bit data path with 16-bit peripheral address
    nxt(); psel_c = 1; penable = 1; pwrite = 1; paddr = 32'h1A10_0F08;
    pwdata_c = 64'h1122_3344_5566_7788; pstrb_c = 8'hF0; gnt = 1;
    #2 chk("w64_be", be_c, 8'hF0); chk("w64_add", add_c, 16'h0F08);
       chk("w64_wdata", wdata_c, 64'h1122_3344_5566_7788); chk("w64_pready", pready_c, 1);
    nxt(); idle();
    nxt(); psel_c = 1; penable = 1; pwrite = 0; gnt = 1;
    #2 chk("r64_be", be_c, 8'hFF); chk("r64_pready_gnt", pready_c, 0);
    nxt(); gnt = 0; rvalid = 1; rdata_c = 64'h0123_4567_89AB_CDEF;
    #2 chk("r64_pready", pready_c, 1); chk("r64_prdata", prdata_c, 64'h0123_4567_89AB_CDEF);
    nxt(); idle();

    nxt();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb2per_ext.md
APB2PER_EXT -- requirements
Module: apb2per_ext

Interface
REQ-001 SHALL have parameter PER_ADDR_WIDTH, default 32: peripheral-side address width.
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 32: APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, legal 32 or 64: data width on both sides.
REQ-004 SHALL have parameter WRITE_WAIT_RESP, default 0: 1 = writes complete on r_valid; 0 = writes complete on grant.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0: access timeout; 0 disables the timeout.
REQ-006 SHALL use one clock and an asynchronous, active-low reset; ports clk_i and rst_ni.
REQ-007 SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  DATA_WIDTH  write data
- PWRITE  in  1  write=1
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- per_master_req_o  out  1  request
- per_master_add_o  out  PER_ADDR_WIDTH  address
- per_master_we_o  out  1  write enable
- per_master_wdata_o  out  DATA_WIDTH  write data
- per_master_be_o  out  DATA_WIDTH/8  byte enables
- per_master_gnt_i  in  1  grant
- per_master_r_valid_i  in  1  response valid
- per_master_r_opc_i  in  1  response error (1=error)
- per_master_r_rdata_i  in  DATA_WIDTH  response data

Function
REQ-008 SHALL implement states IDLE, WAIT_RESP and DRAIN; the state register is the only state besides the timeout counter.
REQ-009 SHALL set "access" = PSEL & PENABLE in IDLE; in IDLE with access, req_o=1 and we_o=PWRITE combinationally in the same cycle; otherwise req_o=0 and we_o=0.
REQ-010 SHALL drive add_o = PADDR zero-extended or truncated to PER_ADDR_WIDTH, and wdata_o = PWDATA; be_o = PSTRB when PWRITE=1, all ones when PWRITE=0.
REQ-011 On IDLE+access+gnt with a write and WRITE_WAIT_RESP=0, SHALL assert PREADY=1 and PSLVERR=0 that cycle and remain in IDLE (zero-wait completion).
REQ-012 On IDLE+access+gnt with a read, or with a write when WRITE_WAIT_RESP=1, SHALL hold PREADY=0 and go to WAIT_RESP.
REQ-013 On IDLE+access without gnt, SHALL stay in IDLE with req_o held and PREADY=0.
REQ-014 In WAIT_RESP, req_o=0; on r_valid=1, SHALL assert PREADY=1 and PSLVERR=r_opc_i, and drive PRDATA=r_rdata_i that cycle, then go to IDLE; otherwise PREADY=0.
REQ-015 SHALL drive PRDATA='0 in every cycle other than a WAIT_RESP r_valid completion.
REQ-016 SHALL implement the timeout counter with width $clog2(TIMEOUT_CYCLES+1); it increments in every waiting cycle (IDLE+access without gnt, or WAIT_RESP without r_valid) and clears on any completion, and in IDLE when there is no access.
REQ-017 When TIMEOUT_CYCLES>0, the counter equals TIMEOUT_CYCLES and no normal completion occurs that cycle, SHALL assert PREADY=1 and PSLVERR=1 with req_o forced to 0; the next state is IDLE if in IDLE and DRAIN if in WAIT_RESP.
REQ-018 A normal completion (gnt or r_valid) SHALL take priority over a timeout in the same cycle.
REQ-019 In DRAIN, SHALL hold req_o=0 and PREADY=0, and on the first r_valid discard the response and go to IDLE; any pending APB access waits and is then serviced from IDLE.
REQ-020 If PSEL or PENABLE drops in IDLE before grant, SHALL deassert req_o in that cycle and clear the counter; no completion is signalled.

Reset
REQ-021 On rst_ni=0, SHALL asynchronously force state=IDLE and counter=0; with PSEL=0, outputs SHALL be PREADY=0, PSLVERR=0, PRDATA=0, req_o=0 and we_o=0.
REQ-022 Reset mid-operation (WAIT_RESP or DRAIN) SHALL abandon the transfer; any r_valid received after reset while in IDLE SHALL be ignored.

Verification
REQ-023 Write with WRITE_WAIT_RESP=0, addr 0x1A10_0004, data 0xDEADBEEF, PSTRB 0x3, gnt in the first access cycle -> req_o=1, be_o=0x3, PREADY=1 in the same cycle, PSLVERR=0.
REQ-024 Read with gnt after 2 cycles and r_valid 3 cycles later, rdata 0x1234_5678, opc 0 -> PREADY=1 only in the r_valid cycle, PRDATA=0x12345678, be_o all ones.
REQ-025 Write with WRITE_WAIT_RESP=1 and r_valid with opc=1 -> PREADY=1, PSLVERR=1 in the r_valid cycle.
REQ-026 TIMEOUT_CYCLES=4 with gnt never asserted -> PREADY=PSLVERR=1 on the 5th access cycle, req_o=0 in that cycle, state returns to IDLE.
REQ-027 TIMEOUT_CYCLES=4 read granted but no r_valid until the timeout -> error completion and DRAIN; a back-to-back read is held (req_o=0) until the late r_valid arrives, then is issued and completes with its own data.
REQ-028 DATA_WIDTH=64: write with PSTRB 0xF0 -> be_o=0xF0; read returns a 64-bit rdata unchanged on PRDATA.
